// File: rtl/nn_scan_pkg.sv
// Shared types and helpers for the neuron weight/bias scan-chain loader.
package nn_scan_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE} scan_ld_st_e;

   localparam int CSUM_W_DEFAULT = 16;

   // Each neuron contributes its weights, its bias and its scan_do output register.
   function automatic int scan_chain_depth(input int num_neurons, input int num_inputs);
      return num_neurons * (num_inputs + 2);
   endfunction

endpackage

// File: rtl/scan_csum_acc.sv
// Additive checksum accumulator (mod 2^CsumWidth, data zero-extended).
module scan_csum_acc #(
   parameter int DataWidth = 8,
   parameter int CsumWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 i_clear,
   input  logic                 i_en,
   input  logic [DataWidth-1:0] i_data,
   output logic [CsumWidth-1:0] o_sum
);

   logic [CsumWidth-1:0] r_sum;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_sum <= '0;
      end else if (i_clear) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= r_sum + CsumWidth'(i_data);
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/weight_scan_loader.sv
// Stream-to-scan-chain feeder: one shift per accepted word, length check, done/error reporting.
// Define SCAN_READBACK_EN to add a checksum-verified recirculation pass after a good load.
module weight_scan_loader
   import nn_scan_pkg::*;
#(
   parameter int WeigthsWidth = 8,
   parameter int NumNeurons   = 4,
   parameter int NumInputs    = 4,
   parameter int ChainDepth   = scan_chain_depth(NumNeurons, NumInputs),
   parameter int CsumWidth    = CSUM_W_DEFAULT
) (
   input  logic                             clk_i,
   input  logic                             reset_ni,
   input  logic                             load_start_i,
   input  logic                             s_valid_i,
   output logic                             s_ready_o,
   input  logic [WeigthsWidth-1:0]          s_data_i,
   input  logic                             s_last_i,
   output logic                             shift_o,
   output logic [WeigthsWidth-1:0]          scan_do,
   input  logic [WeigthsWidth-1:0]          scan_di,
   output logic                             busy_o,
   output logic                             done_o,
   output logic                             err_o,
   output logic [$clog2(ChainDepth+1)-1:0]  word_cnt_o
);

   localparam int CntW = $clog2(ChainDepth + 1);

   scan_ld_st_e             r_state, w_state_nxt;
   logic [CntW-1:0]         r_word_cnt;
   logic [CntW-1:0]         w_cnt_inc;
   logic                    w_cnt_full;
   logic                    r_err;
   logic                    w_err_set;
   logic                    w_start;
   logic                    w_accept;
   logic [WeigthsWidth-1:0] r_scan_hold;
   logic [CsumWidth-1:0]    w_csum;

   assign w_start    = load_start_i && (r_state == ST_IDLE);
   assign s_ready_o  = (r_state == ST_LOAD);
   assign w_accept   = s_valid_i && s_ready_o;
   assign w_cnt_inc  = r_word_cnt + 1'b1;
   assign w_cnt_full = (w_cnt_inc == CntW'(ChainDepth));
   assign busy_o     = (r_state != ST_IDLE);
   assign done_o     = (r_state == ST_DONE);
   assign err_o      = r_err;
   assign word_cnt_o = r_word_cnt;

   scan_csum_acc #(.DataWidth(WeigthsWidth), .CsumWidth(CsumWidth)) u_csum (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .i_clear  (w_start),
      .i_en     (w_accept),
      .i_data   (s_data_i),
      .o_sum    (w_csum)
   );

`ifdef SCAN_READBACK_EN
   logic [CntW-1:0]      r_vfy_cnt;
   logic                 w_vfy_load;
   logic                 w_vfy_active;
   logic [CsumWidth-1:0] w_rcsum;
   logic [CsumWidth-1:0] w_rcsum_final;

   assign w_vfy_active  = (r_state == ST_VERIFY);
   // The last recirculated word is folded in combinationally so the compare lands on the final shift.
   assign w_rcsum_final = w_rcsum + CsumWidth'(scan_di);

   scan_csum_acc #(.DataWidth(WeigthsWidth), .CsumWidth(CsumWidth)) u_rcsum (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .i_clear  (w_start),
      .i_en     (w_vfy_active),
      .i_data   (scan_di),
      .o_sum    (w_rcsum)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_vfy_cnt <= '0;
      end else if (w_vfy_load) begin
         r_vfy_cnt <= CntW'(ChainDepth - 1);
      end else if (w_vfy_active) begin
         r_vfy_cnt <= r_vfy_cnt - 1'b1;
      end
   end
`else
   logic w_unused_scan_di;
   assign w_unused_scan_di = ^scan_di;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_err_set   = 1'b0;
`ifdef SCAN_READBACK_EN
      w_vfy_load  = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (load_start_i) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_accept) begin
               if (s_last_i && w_cnt_full) begin
`ifdef SCAN_READBACK_EN
                  w_state_nxt = ST_VERIFY;
                  w_vfy_load  = 1'b1;
`else
                  w_state_nxt = ST_DONE;
`endif
               end else if (s_last_i || w_cnt_full) begin
                  w_err_set   = 1'b1;
                  w_state_nxt = ST_DONE;
               end
            end
         end
`ifdef SCAN_READBACK_EN
         ST_VERIFY: begin
            if (r_vfy_cnt == '0) begin
               w_err_set   = (w_rcsum_final != w_csum);
               w_state_nxt = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Zero-latency stream mux; scan_do holds its last driven word when not shifting.
   always_comb begin
      shift_o = w_accept;
      scan_do = r_scan_hold;
      if (w_accept) scan_do = s_data_i;
`ifdef SCAN_READBACK_EN
      if (w_vfy_active) begin
         shift_o = 1'b1;
         scan_do = scan_di;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state     <= ST_IDLE;
         r_word_cnt  <= '0;
         r_err       <= 1'b0;
         r_scan_hold <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_word_cnt <= '0;
            r_err      <= 1'b0;
         end else begin
            if (w_accept)  r_word_cnt <= w_cnt_inc;
            if (w_err_set) r_err      <= 1'b1;
         end
         if (shift_o) r_scan_hold <= scan_do;
      end
   end

endmodule
